// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-style port between an instruction and a data
// requester.
//
// Request path is combinational. The granted requester's fields go straight to
// mem_*. A grant that the memory stalls (mem_req=1, mem_addr_ok=0) is locked
// until it is accepted. Each accepted transaction pushes its owner ID into a
// tag FIFO. Each mem_data_ok pops the head of that FIFO and steers the
// response to its owner.
//
// Build option: define SRAM_ARB_ROUND_ROBIN_EN to alternate the grant when
// both requesters contend. Without it, data has fixed priority over inst.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   inst_* / data_*               requester request fields (in),
//                                 addr_ok / data_ok / rdata (out)
//   mem_req .. mem_wdata          shared-port request (out)
//   mem_addr_ok, mem_data_ok,
//   mem_rdata                     shared-port handshake / read data (in)
module sram_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic {ST_FREE = 1'b0, ST_LOCKED = 1'b1} arb_state_t;

  arb_state_t                 state_r, state_nxt_s;
  logic                       lock_owner_r, lock_owner_nxt_s;
  logic [PTR_W-1:0]           wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]           count_r;
  logic [MAX_OUTSTANDING-1:0] tag_r;
  logic                       grant_s, granted_req_s, full_s, empty_s;
  logic                       push_s, pop_s, head_s;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic                       rr_last_r;
`endif

  assign full_s  = (count_r == CNT_MAX);
  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign head_s  = tag_r[rd_ptr_r];

  // Grant selection: a locked grant wins, otherwise contention policy.
  always_comb begin
    grant_s = OWN_INST;
    if (state_r == ST_LOCKED) begin
      grant_s = lock_owner_r;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    end else if (inst_req && data_req) begin
      grant_s = ~rr_last_r;
`endif
    end else if (data_req) begin
      grant_s = OWN_DATA;
    end else begin
      grant_s = OWN_INST;
    end
  end

  // Reset forces the request and response strobes low without waiting for
  // clk, even while requesters keep their req lines high.
  assign granted_req_s = (grant_s == OWN_DATA) ? data_req : inst_req;
  assign mem_req       = ~rst & granted_req_s & ~full_s;
  assign push_s        = mem_req & mem_addr_ok;
  assign pop_s         = ~rst & mem_data_ok & ~empty_s;

  assign inst_addr_ok = push_s & (grant_s == OWN_INST);
  assign data_addr_ok = push_s & (grant_s == OWN_DATA);
  assign inst_data_ok = pop_s & (head_s == OWN_INST);
  assign data_data_ok = pop_s & (head_s == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Request field mux toward the shared port.
  always_comb begin
    if (grant_s == OWN_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wstrb = data_wstrb;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_addr  = inst_addr;
      mem_wstrb = inst_wstrb;
      mem_wdata = inst_wdata;
    end
  end

  // Lock FSM next state: a stalled request pins its owner until accepted.
  always_comb begin
    state_nxt_s      = state_r;
    lock_owner_nxt_s = lock_owner_r;
    case (state_r)
      ST_FREE: begin
        if (mem_req && !mem_addr_ok) begin
          state_nxt_s      = ST_LOCKED;
          lock_owner_nxt_s = grant_s;
        end else begin
          state_nxt_s = ST_FREE;
        end
      end
      ST_LOCKED: begin
        if (push_s) begin
          state_nxt_s = ST_FREE;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: begin
        state_nxt_s      = ST_FREE;
        lock_owner_nxt_s = OWN_INST;
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_FREE;
      lock_owner_r <= OWN_INST;
    end else begin
      state_r      <= state_nxt_s;
      lock_owner_r <= lock_owner_nxt_s;
    end
  end

  // Tag FIFO: owner IDs in acceptance order; pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_r    <= {MAX_OUTSTANDING{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tag_r[wr_ptr_r] <= grant_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Remembers who won the most recent acceptance; the other side wins next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_r <= OWN_INST;
    end else if (push_s) begin
      rr_last_r <= grant_s;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end
`endif

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter: MAX_OUTSTANDING, 4, max accepted-but-unanswered transactions (power of two, 2..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports: inst_req / data_req  input  1  requester transaction valid.
REQ-005 SHALL have ports: inst_wr / data_wr  input  1  1=write, 0=read.
REQ-006 SHALL have ports: inst_size / data_size  input  2  0=byte, 1=half, 2=word.
REQ-007 SHALL have ports: inst_addr / data_addr  input  32  byte address.
REQ-008 SHALL have ports: inst_wstrb / data_wstrb  input  4  byte write strobes.
REQ-009 SHALL have ports: inst_wdata / data_wdata  input  32  write data.
REQ-010 SHALL have ports: inst_addr_ok / data_addr_ok  output  1  request accepted this cycle.
REQ-011 SHALL have ports: inst_data_ok / data_data_ok  output  1  response for that requester this cycle.
REQ-012 SHALL have ports: inst_rdata / data_rdata  output  32  read data, valid with *_data_ok.
REQ-013 SHALL have ports: mem_req, mem_wr, mem_size[2], mem_addr[32], mem_wstrb[4], mem_wdata[32]  output  shared-port request fields.
REQ-014 SHALL have ports: mem_addr_ok, mem_data_ok (1), mem_rdata (32)  input  shared-port handshake and read data.

Function
REQ-015 Request path SHALL be combinational: granted requester's fields muxed onto mem_*; mem_req = granted req AND NOT blocked.
REQ-016 Handshake: a transaction is accepted in a cycle with mem_req=1 and mem_addr_ok=1; only the granted requester's *_addr_ok SHALL pulse, the other SHALL stay 0.
REQ-017 Default arbitration SHALL be fixed priority, data over inst.
REQ-018 Lock: if mem_req=1 and mem_addr_ok=0, the grant SHALL be registered and held in following cycles until acceptance, regardless of the other requester; requesters hold fields stable while pending.
REQ-019 Tag FIFO: on acceptance the owner ID (0=inst, 1=data) SHALL be pushed into a MAX_OUTSTANDING-deep FIFO; on mem_data_ok the head SHALL be popped and the owner's *_data_ok pulsed for that cycle.
REQ-020 inst_rdata and data_rdata SHALL both equal mem_rdata combinationally; response latency through block is zero cycles.
REQ-021 Full: when count==MAX_OUTSTANDING, mem_req SHALL be 0 (blocked) even if a pop occurs the same cycle; lock state retained.
REQ-022 Empty: mem_data_ok with count==0 SHALL be ignored (no *_data_ok, count stays 0).
REQ-023 Simultaneous push and pop SHALL leave count unchanged; read/write pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-024 Responses SHALL be delivered strictly in acceptance order; writes also occupy a FIFO entry and receive data_ok.

Reset
REQ-025 On rst assertion (async) FIFO SHALL empty (count, pointers 0), lock cleared, round-robin pointer set to inst, all outputs that are registered-state-derived 0: mem_req=0, *_addr_ok=0, *_data_ok=0.
REQ-026 Transactions in flight at reset SHALL be discarded; late mem_data_ok after reset falls under REQ-022.

Configuration
REQ-027 Macro SRAM_ARB_ROUND_ROBIN_EN defined: when both request with no lock, grant SHALL go to the requester not granted at the most recent acceptance (pointer updates on each acceptance).
REQ-028 Macro undefined: fixed data-over-inst priority per REQ-017; no round-robin register synthesized.

Verification
REQ-029 Only inst_req=1 addr 0x1C000000, mem_addr_ok=1 same cycle, mem_data_ok 2 cycles later rdata 0x02800000 -> inst_addr_ok pulse, inst_data_ok pulse with inst_rdata=0x02800000, data_* stay 0.
REQ-030 Both req same cycle, mem_addr_ok=1 -> data accepted first; next cycle inst accepted; responses route data then inst (round-robin build: alternates over 4 back-to-back cycles).
REQ-031 inst_req pending with mem_addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> mem_addr stays inst addr until acceptance, then data granted.
REQ-032 Accept 4 reads with no mem_data_ok -> mem_req=0 on 5th while both requesting; one mem_data_ok -> still blocked that cycle, mem_req=1 next cycle.
REQ-033 mem_data_ok=1 with empty FIFO -> no *_data_ok; rst asserted mid-cycle with 2 outstanding -> mem_req and count 0 immediately, without waiting for clk.
